bus_arbiter: RTL

- Shares the common read/data/write bus between NREQ bus masters: control unit, a debug loader and a DMA-style copier.
- Each granted requester performs one move transaction:
  - drive source address on read_bus;
  - pulse read_clk and capture data_bus;
  - optionally drive destination address on write_bus and the captured word on data_bus, then pulse write_clk.
- Sits between the requesters and the shared bus. It is the sole generator of read_clk/write_clk when the shared bus is in multi-master mode.

---
 rtl/bus_arbiter_pkg.sv | 37 +++
 rtl/bus_arbiter_rr_picker.sv | 35 +++
 rtl/bus_arbiter.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/bus_arbiter_pkg.sv
// Shared definitions for the bus_arbiter slice: default sizes, FSM encodings, helpers.
// BUS_ARB_LOCK_EN adds the ownership-lock constants.
package bus_arbiter_pkg;

   localparam int WORD_W_DEF = 16;
   localparam int NREQ_DEF   = 3;
   localparam int IDX_W_DEF  = 2;

   localparam logic [2:0] S_IDLE    = 3'd0;
   localparam logic [2:0] S_RSETUP  = 3'd1;
   localparam logic [2:0] S_RSTROBE = 3'd2;
   localparam logic [2:0] S_CAPTURE = 3'd3;
   localparam logic [2:0] S_WSETUP  = 3'd4;
   localparam logic [2:0] S_WSTROBE = 3'd5;
   localparam logic [2:0] S_DONE    = 3'd6;

   typedef enum logic [2:0] {
      ST_IDLE    = S_IDLE,
      ST_RSETUP  = S_RSETUP,
      ST_RSTROBE = S_RSTROBE,
      ST_CAPTURE = S_CAPTURE,
      ST_WSETUP  = S_WSETUP,
      ST_WSTROBE = S_WSTROBE,
      ST_DONE    = S_DONE
   } state_t;

`ifdef BUS_ARB_LOCK_EN
   // Maximum number of consecutive transactions one locked owner may hold.
   localparam int LOCK_MAX = 4;
`endif

   // Next index after idx, wrapping from n-1 back to 0.
   function automatic int wrap_inc(input int idx, input int n);
      return (idx >= n - 1) ? 0 : idx + 1;
   endfunction

endpackage

// File: rtl/bus_arbiter_rr_picker.sv
// Combinational round-robin picker: first requester at or after ptr wins.
// Returns one-hot winner, its index, and whether any request is present.
module rr_picker
   import bus_arbiter_pkg::*;
#(
   parameter int NREQ  = NREQ_DEF,
   parameter int IDX_W = IDX_W_DEF
) (
   input  logic [NREQ-1:0]  req,
   input  logic [IDX_W-1:0] ptr,
   output logic [NREQ-1:0]  win,
   output logic [IDX_W-1:0] win_idx,
   output logic             any
);

   int   cand;
   logic found;

   always_comb begin
      win     = '0;
      win_idx = '0;
      found   = 1'b0;
      cand    = 0;
      for (int i = 0; i < NREQ; i++) begin
         cand = (int'(ptr) + i) % NREQ;
         if (!found && req[cand]) begin
            found     = 1'b1;
            win[cand] = 1'b1;
            win_idx   = IDX_W'(cand);
         end
      end
      any = |req;
   end

endmodule

// File: rtl/bus_arbiter.sv
// Round-robin owner of the shared read/data/write bus; runs one move per grant.
// Optional BUS_ARB_LOCK_EN adds a lock input letting an owner keep the bus for a bounded run.
module bus_arbiter
   import bus_arbiter_pkg::*;
#(
   parameter int NREQ   = NREQ_DEF,
   parameter int WORD_W = WORD_W_DEF,
   parameter int IDX_W  = IDX_W_DEF
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [NREQ-1:0]        req,
   input  logic [NREQ*WORD_W-1:0] src_addr,
   input  logic [NREQ*WORD_W-1:0] dst_addr,
   input  logic [NREQ-1:0]        wr_en,
`ifdef BUS_ARB_LOCK_EN
   input  logic [NREQ-1:0]        lock,
`endif
   output logic [NREQ-1:0]        grant,
   output logic [NREQ-1:0]        done,
   output logic [WORD_W-1:0]      rd_data,
   output logic                   read_clk,
   output logic                   write_clk,
   output logic [WORD_W-1:0]      read_bus,
   output logic [WORD_W-1:0]      write_bus,
   output logic [WORD_W-1:0]      data_out,
   output logic                   data_oe,
   input  logic [WORD_W-1:0]      data_in,
   output logic [2:0]             dbg_state
);

   // Requester side: req is a level held until done; the arbiter latches the
   // winner's src/dst/wr_en in IDLE and never re-samples them mid-transaction.

   state_t              state_q, state_d;
   logic [NREQ-1:0]     grant_q;
   logic [IDX_W-1:0]    owner_q;
   logic [IDX_W-1:0]    rr_ptr_q;
   logic [WORD_W-1:0]   src_q, dst_q, rd_data_q;
   logic                wr_q;

   logic [NREQ-1:0]     rr_win, sel_win;
   logic [IDX_W-1:0]    rr_idx, sel_idx;
   logic                rr_any;

`ifdef BUS_ARB_LOCK_EN
   logic                lock_pend_q;
   logic [2:0]          lock_cnt_q;
`endif

   rr_picker #(
      .NREQ  (NREQ),
      .IDX_W (IDX_W)
   ) u_picker (
      .req     (req),
      .ptr     (rr_ptr_q),
      .win     (rr_win),
      .win_idx (rr_idx),
      .any     (rr_any)
   );

   always_comb begin
      sel_win = rr_win;
      sel_idx = rr_idx;
`ifdef BUS_ARB_LOCK_EN
      // A pending lock pre-empts round-robin only while its owner still requests.
      if (lock_pend_q && req[owner_q]) begin
         sel_win = NREQ'(1) << owner_q;
         sel_idx = owner_q;
      end
`endif
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      read_clk  = 1'b0;
      write_clk = 1'b0;
      read_bus  = '0;
      write_bus = '0;
      data_out  = '0;
      data_oe   = 1'b0;
      done      = '0;
      case (state_q)
         ST_IDLE: begin
            if (rr_any) state_d = ST_RSETUP;
         end
         ST_RSETUP: begin
            read_bus = src_q;
            state_d  = ST_RSTROBE;
         end
         ST_RSTROBE: begin
            read_bus = src_q;
            read_clk = 1'b1;
            state_d  = ST_CAPTURE;
         end
         ST_CAPTURE: begin
            read_bus = src_q;
            state_d  = wr_q ? ST_WSETUP : ST_DONE;
         end
         ST_WSETUP: begin
            write_bus = dst_q;
            data_out  = rd_data_q;
            data_oe   = 1'b1;
            state_d   = ST_WSTROBE;
         end
         ST_WSTROBE: begin
            write_bus = dst_q;
            data_out  = rd_data_q;
            data_oe   = 1'b1;
            write_clk = 1'b1;
            state_d   = ST_DONE;
         end
         ST_DONE: begin
            done    = grant_q;
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         grant_q     <= '0;
         owner_q     <= '0;
         rr_ptr_q    <= '0;
         src_q       <= '0;
         dst_q       <= '0;
         wr_q        <= 1'b0;
         rd_data_q   <= '0;
`ifdef BUS_ARB_LOCK_EN
         lock_pend_q <= 1'b0;
         lock_cnt_q  <= '0;
`endif
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (rr_any) begin
                  grant_q <= sel_win;
                  owner_q <= sel_idx;
                  src_q   <= src_addr[int'(sel_idx)*WORD_W +: WORD_W];
                  dst_q   <= dst_addr[int'(sel_idx)*WORD_W +: WORD_W];
                  wr_q    <= wr_en[sel_idx];
`ifdef BUS_ARB_LOCK_EN
                  // Run length restarts whenever ownership changes hands.
                  if (lock_pend_q && (sel_idx == owner_q)) begin
                     lock_cnt_q <= lock_cnt_q + 3'd1;
                  end else begin
                     lock_cnt_q <= 3'd1;
                  end
                  lock_pend_q <= 1'b0;
`endif
               end
            end
            ST_CAPTURE: begin
               rd_data_q <= data_in;
            end
            ST_DONE: begin
               grant_q <= '0;
`ifdef BUS_ARB_LOCK_EN
               if (lock[owner_q] && (lock_cnt_q < 3'(LOCK_MAX))) begin
                  lock_pend_q <= 1'b1;
               end else begin
                  rr_ptr_q <= IDX_W'(wrap_inc(int'(owner_q), NREQ));
               end
`else
               rr_ptr_q <= IDX_W'(wrap_inc(int'(owner_q), NREQ));
`endif
            end
            default: ;
         endcase
      end
   end

   assign grant     = grant_q;
   assign rd_data   = rd_data_q;
   assign dbg_state = state_q;

endmodule
